// File: rtl/bomb_game_ctrl.sv
// ---------------------------------------------------------------------------
// bomb_game_ctrl
//   Game-control FSM that sits directly upstream of the two-digit countdown
//   block. It debounces the arm/enter pushbuttons, collects a 4-digit BCD code
//   from the switches, drives the countdown's start/success inputs, and watches
//   the countdown digits for the underflow marker that means time ran out.
//
//   Optional feature macro: BOMB_STRIKE_LIMIT_EN
//     defined   : reaching MAX_STRIKES wrong codes explodes the bomb
//     undefined : wrong codes only count strikes; BOOM only on timer expiry
//
// Ports
//   clk        in   system clock, shared with the countdown block
//   rst        in   asynchronous reset, active-low
//   btn_arm    in   raw pushbutton, arms the bomb
//   btn_enter  in   raw pushbutton, commits the digit on sw
//   sw         in   [3:0] digit value (BCD 0-9)
//   s2, s1     in   [3:0] countdown tens / units digits
//   start      out  countdown run enable
//   success    out  code accepted, countdown freezes
//   boom       out  exploded indicator
//   entry      out  [15:0] digits entered so far, newest in the low nibble
//   digit_cnt  out  [2:0] number of digits entered (0-4)
//   strikes    out  [1:0] wrong codes entered (saturates at 3)
// ---------------------------------------------------------------------------
module bomb_game_ctrl #(
   parameter int          DEBOUNCE_CYCLES = 4,
   parameter logic [15:0] SECRET_CODE     = 16'h1234,
   parameter int          MAX_STRIKES     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_arm,
   input  logic        btn_enter,
   input  logic [3:0]  sw,
   input  logic [3:0]  s2,
   input  logic [3:0]  s1,
   output logic        start,
   output logic        success,
   output logic        boom,
   output logic [15:0] entry,
   output logic [2:0]  digit_cnt,
   output logic [1:0]  strikes
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]       STRIKE_LIMIT = 2'(MAX_STRIKES);
`ifdef BOMB_STRIKE_LIMIT_EN
   localparam bit               LIMIT_EN = 1'b1;
`else
   localparam bit               LIMIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, ARMED, CHECK, DEFUSED, BOOM} state_t;

   // index 0 = arm, index 1 = enter
   logic [1:0]       btn_raw;
   logic [1:0]       sync_p0, sync_p1;
   logic [1:0]       level;
   logic [1:0]       rise_p0, pulse_p1;
   logic [CNT_W-1:0] cnt [2];

   logic             arm_pulse, enter_pulse, expired;
   state_t           state, state_nxt;
   logic [15:0]      entry_nxt;
   logic [2:0]       digit_nxt;
   logic [1:0]       strikes_nxt;

   assign btn_raw = {btn_enter, btn_arm};

   // ---- stage p0/p1: synchroniser, debounce, edge pulse ----
   // The accepted level flips only after DEBOUNCE_CYCLES consecutive samples
   // disagree with it; any agreeing sample restarts the count. The rising-edge
   // pulse is retimed one extra flop so presses reach the FSM D+3 cycles late.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0  <= '0;
         sync_p1  <= '0;
         level    <= '0;
         rise_p0  <= '0;
         pulse_p1 <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         sync_p0  <= btn_raw;
         sync_p1  <= sync_p0;
         pulse_p1 <= rise_p0;
         rise_p0  <= '0;
         for (int i = 0; i < 2; i++) begin
            if (sync_p1[i] != level[i]) begin
               if (cnt[i] == CNT_MAX) begin
                  level[i]   <= sync_p1[i];
                  rise_p0[i] <= sync_p1[i];
                  cnt[i]     <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   assign arm_pulse   = pulse_p1[0];
   assign enter_pulse = pulse_p1[1];
   // Countdown wraps to FF after 00: that marker is the expiry event.
   assign expired     = ({s2, s1} == 8'hFF);

   // ---- stage p2: game FSM next-state ----
   always_comb begin
      state_nxt   = state;
      entry_nxt   = entry;
      digit_nxt   = digit_cnt;
      strikes_nxt = strikes;
      case (state)
         IDLE, DEFUSED, BOOM: begin
            if (arm_pulse) begin
               state_nxt   = ARMED;
               entry_nxt   = '0;
               digit_nxt   = '0;
               strikes_nxt = '0;
            end
         end
         ARMED: begin
            if (expired) begin
               state_nxt = BOOM;
            end else if (enter_pulse && (sw <= 4'd9)) begin
               entry_nxt = {entry[11:0], sw};
               digit_nxt = digit_cnt + 3'd1;
               if (digit_cnt == 3'd3) state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (expired) begin
               state_nxt = BOOM;
            end else if (entry == SECRET_CODE) begin
               state_nxt = DEFUSED;
            end else begin
               strikes_nxt = (strikes == 2'd3) ? 2'd3 : strikes + 2'd1;
               entry_nxt   = '0;
               digit_nxt   = '0;
               state_nxt   = ARMED;
               if (LIMIT_EN && (strikes_nxt == STRIKE_LIMIT)) state_nxt = BOOM;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         entry     <= '0;
         digit_cnt <= '0;
         strikes   <= '0;
         start     <= 1'b0;
         success   <= 1'b0;
         boom      <= 1'b0;
      end else begin
         state     <= state_nxt;
         entry     <= entry_nxt;
         digit_cnt <= digit_nxt;
         strikes   <= strikes_nxt;
         start     <= (state_nxt == ARMED) || (state_nxt == CHECK) || (state_nxt == DEFUSED);
         success   <= (state_nxt == DEFUSED);
         boom      <= (state_nxt == BOOM);
      end
   end

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bomb_game_ctrl
//   Self-checking bench for bomb_game_ctrl: directed scenarios for timing and
//   boundary behaviour, then random button/expiry activity checked against a
//   behavioural game model (digit list, strike count, game phase).
// ---------------------------------------------------------------------------
module tb_bomb_game_ctrl;

   localparam int          DB     = 4;
   localparam logic [15:0] SECRET = 16'h1234;
   localparam int          MAXS   = 3;

   localparam int M_IDLE = 0, M_ARMED = 1, M_DEFUSED = 2, M_BOOM = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        btn_arm = 1'b0, btn_enter = 1'b0;
   logic [3:0]  sw = 4'd0, s2 = 4'd3, s1 = 4'd0;
   logic        start, success, boom;
   logic [15:0] entry;
   logic [2:0]  digit_cnt;
   logic [1:0]  strikes;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model
   int m_st = M_IDLE;
   int m_dig[$];
   int m_strikes = 0;

   bomb_game_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .SECRET_CODE    (SECRET),
      .MAX_STRIKES    (MAXS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_arm  (btn_arm),
      .btn_enter(btn_enter),
      .sw       (sw),
      .s2       (s2),
      .s1       (s1),
      .start    (start),
      .success  (success),
      .boom     (boom),
      .entry    (entry),
      .digit_cnt(digit_cnt),
      .strikes  (strikes)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int m_entry();
      int e = 0;
      foreach (m_dig[i]) e = e * 16 + m_dig[i];
      return e;
   endfunction

   task automatic m_arm();
      if (m_st != M_ARMED) begin
         m_st = M_ARMED;
         m_dig.delete();
         m_strikes = 0;
      end
   endtask

   task automatic m_enter(input int d);
      if (m_st == M_ARMED && d <= 9) begin
         m_dig.push_back(d);
         if (m_dig.size() == 4) begin
            if (m_entry() == int'(SECRET)) begin
               m_st = M_DEFUSED;
            end else begin
               if (m_strikes < 3) m_strikes++;
               m_dig.delete();
`ifdef BOMB_STRIKE_LIMIT_EN
               if (m_strikes == MAXS) m_st = M_BOOM;
`endif
            end
         end
      end
   endtask

   task automatic m_expire();
      if (m_st == M_ARMED) m_st = M_BOOM;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_start"},   32'(start),     32'((m_st == M_ARMED) || (m_st == M_DEFUSED)));
      chk({tag, "_success"}, 32'(success),   32'(m_st == M_DEFUSED));
      chk({tag, "_boom"},    32'(boom),      32'(m_st == M_BOOM));
      chk({tag, "_entry"},   32'(entry),     32'(m_entry()));
      chk({tag, "_digits"},  32'(digit_cnt), 32'(m_dig.size()));
      chk({tag, "_strikes"}, 32'(strikes),   32'(m_strikes));
   endtask

   // clean press: hold long enough to be accepted, then release and settle
   task automatic do_arm(input string tag);
      btn_arm = 1'b1;
      step(DB + 4);
      btn_arm = 1'b0;
      step(DB + 4);
      m_arm();
      chk_all(tag);
   endtask

   task automatic do_enter(input string tag, input logic [3:0] d);
      sw = d;
      btn_enter = 1'b1;
      step(DB + 4);
      btn_enter = 1'b0;
      step(DB + 4);
      m_enter(int'(d));
      chk_all(tag);
   endtask

   task automatic do_expire(input string tag);
      {s2, s1} = 8'hFF;
      step(1);
      {s2, s1} = 8'h30;
      step(1);
      m_expire();
      chk_all(tag);
   endtask

   initial begin
      int r, d, sh;

      // reset state
      #2;
      chk("rst_start", 32'(start), 0);
      chk("rst_success", 32'(success), 0);
      chk("rst_boom", 32'(boom), 0);
      chk("rst_entry", 32'(entry), 0);
      step(2);
      rst = 1'b1;
      step(2);
      chk_all("idle");

      // arm: pulse reaches FSM in cycle DB+3, start rises one cycle later
      btn_arm = 1'b1;
      step(DB + 3);
      chk("arm_early_start", 32'(start), 0);
      step(1);
      chk("arm_start", 32'(start), 1);
      chk("arm_entry", 32'(entry), 0);
      chk("arm_digits", 32'(digit_cnt), 0);
      btn_arm = 1'b0;
      step(DB + 4);
      m_arm();
      chk_all("armed");

      // correct code; 4th digit timed
      do_enter("d1", 4'd1);
      do_enter("d2", 4'd2);
      do_enter("d3", 4'd3);
      sw = 4'd4;
      btn_enter = 1'b1;
      step(DB + 4);
      chk("d4_digits", 32'(digit_cnt), 4);
      chk("d4_check_success", 32'(success), 0);
      step(1);
      chk("defuse_success", 32'(success), 1);
      chk("defuse_boom", 32'(boom), 0);
      chk("defuse_entry", 32'(entry), 32'h1234);
      btn_enter = 1'b0;
      step(DB + 4);
      m_enter(4);
      chk_all("defused");

      // re-arm from DEFUSED, then wrong codes
      do_arm("rearm");
      do_enter("w1a", 4'd1); do_enter("w1b", 4'd2);
      do_enter("w1c", 4'd3); do_enter("w1d", 4'd5);
      chk("wrong1_strikes", 32'(strikes), 1);
      chk("wrong1_entry", 32'(entry), 0);
      chk("wrong1_start", 32'(start), 1);
      for (int k = 0; k < 2; k++) begin
         do_enter("wx", 4'd9); do_enter("wx", 4'd9);
         do_enter("wx", 4'd9); do_enter("wx", 4'd9);
      end
`ifdef BOMB_STRIKE_LIMIT_EN
      chk("limit_boom", 32'(boom), 1);
      chk("limit_start", 32'(start), 0);
`else
      chk("nolimit_strikes", 32'(strikes), 3);
      chk("nolimit_boom", 32'(boom), 0);
      do_enter("sat", 4'd0); do_enter("sat", 4'd0);
      do_enter("sat", 4'd0); do_enter("sat", 4'd0);
      chk("sat_strikes", 32'(strikes), 3);
`endif

      // expiry in the same cycle as the 4th correct pulse
      do_arm("rearm2");
      do_enter("e1", 4'd1); do_enter("e2", 4'd2); do_enter("e3", 4'd3);
      sw = 4'd4;
      btn_enter = 1'b1;
      step(DB + 3);
      {s2, s1} = 8'hFF;
      step(1);
      chk("exp_boom", 32'(boom), 1);
      chk("exp_success", 32'(success), 0);
      {s2, s1} = 8'h30;
      btn_enter = 1'b0;
      step(DB + 4);
      m_expire();
      chk_all("exploded");

      // bounce, then a clean hold: exactly one digit
      do_arm("rearm3");
      sw = 4'd7;
      for (int i = 0; i < 10; i++) begin
         btn_enter = ~i[0];
         step(1);
      end
      btn_enter = 1'b1;
      step(DB + 3);
      btn_enter = 1'b0;
      step(DB + 6);
      m_enter(7);
      chk("bounce_digits", 32'(digit_cnt), 1);
      chk_all("bounce");
      do_enter("badsw", 4'hA);

      // reset during CHECK with a strike on the board
      do_enter("r1", 4'd0); do_enter("r2", 4'd0); do_enter("r3", 4'd0);
      do_enter("r4", 4'd9); do_enter("r5", 4'd9); do_enter("r6", 4'd9);
      chk("pre_rst_strikes", 32'(strikes), 1);
      sw = 4'd9;
      btn_enter = 1'b1;
      step(DB + 4);
      chk("in_check_digits", 32'(digit_cnt), 4);
      rst = 1'b0;
      #1;
      chk("arst_start", 32'(start), 0);
      chk("arst_success", 32'(success), 0);
      chk("arst_boom", 32'(boom), 0);
      chk("arst_strikes", 32'(strikes), 0);
      btn_enter = 1'b0;
      step(3);
      rst = 1'b1;
      step(DB + 6);
      m_st = M_IDLE;
      m_dig.delete();
      m_strikes = 0;
      chk_all("post_rst");
      do_arm("post_rst_arm");

      // random play against the model
      for (int it = 0; it < 70; it++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            do_arm("rnd_arm");
         end else if (r == 1) begin
            do_expire("rnd_exp");
         end else begin
            if ($urandom_range(0, 1) == 1 && m_dig.size() < 4) begin
               sh = 12 - 4 * m_dig.size();
               d  = int'((SECRET >> sh) & 16'hF);
            end else begin
               d = $urandom_range(0, 15);
            end
            do_enter("rnd_enter", 4'(d));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bomb_game_ctrl.md
# bomb_game_ctrl

Game-control FSM directly upstream of the two-digit countdown display block. It debounces the player's pushbuttons, accepts a 4-digit code keyed in on switches, and drives the countdown's `start` and `success` inputs. It consumes the countdown's BCD digits `s2`/`s1` to detect expiry and declare the bomb exploded.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable `clk` samples required to accept a button level.
- `SECRET_CODE`, default 16'h1234: 4 BCD digits, most significant entered first.
- `MAX_STRIKES`, default 3: wrong entries that cause BOOM (only with `BOMB_STRIKE_LIMIT_EN`).

Ports:
- `clk`  in  1  system clock; same clock as the countdown block.
- `rst`  in  1  asynchronous reset, active-low.
- `btn_arm`  in  1  raw pushbutton; arms the bomb.
- `btn_enter`  in  1  raw pushbutton; commits the digit on `sw`.
- `sw`  in  4  digit value, BCD 0–9.
- `s2`  in  4  countdown tens digit.
- `s1`  in  4  countdown units digit.
- `start`  out  1  to countdown; high while counting.
- `success`  out  1  to countdown; high after correct code.
- `boom`  out  1  exploded indicator.
- `entry`  out  16  entered digits, shifted left; for display.
- `digit_cnt`  out  3  digits entered so far (0–4).
- `strikes`  out  2  wrong entries so far.

## Operation
- Button path: 2-flop synchroniser, then a debounce counter. The accepted level changes only after `DEBOUNCE_CYCLES` consecutive equal samples. A single-cycle pulse fires on the accepted rising edge. Button pulses arrive `DEBOUNCE_CYCLES`+3 cycles after a clean press.
- States: IDLE, ARMED, CHECK, DEFUSED, BOOM. Reset enters IDLE.
- IDLE: `start`=0. An arm pulse clears `entry`, `digit_cnt`, `strikes` and goes to ARMED.
- ARMED: `start`=1.
  - Enter pulse with `sw`≤9: `entry` ← {`entry`[11:0], `sw`}, `digit_cnt`+1.
  - Enter pulse with `sw`>9: ignored.
  - When `digit_cnt` reaches 4, go to CHECK on the next cycle.
- CHECK, 1 cycle, `start` stays 1:
  - `entry`==`SECRET_CODE` → DEFUSED.
  - Otherwise `strikes`+1 (saturating at 3), `entry` and `digit_cnt` cleared, return to ARMED. With strike limit enabled and the new `strikes`==`MAX_STRIKES` → BOOM.
- Expiry: in ARMED or CHECK, {`s2`,`s1`}==8'hFF (countdown underflow marker after 00) → BOOM. Expiry has priority over a simultaneous enter pulse or CHECK result.
- DEFUSED: `success`=1, `start`=1 (display freezes at the remaining time once the countdown honours `success`). An arm pulse re-arms as from IDLE.
- BOOM: `boom`=1, `start`=0; the countdown then shows 00. An arm pulse re-arms as from IDLE.
- Arm pulses in ARMED or CHECK are ignored.

## Timing
- Reset values: `start`=0, `success`=0, `boom`=0, `entry`=0, `digit_cnt`=0, `strikes`=0. Debounce counters are 0 and accepted levels are 0.
- All outputs are registered.
- Arm pulse at cycle N → `start`=1 at N+1.
- 4th enter pulse at cycle N: `digit_cnt`=4 at N+1, CHECK at N+1, result state at N+2.
- `success` and `boom` assert the cycle the FSM enters DEFUSED or BOOM. They are mutually exclusive and never both 1.
- Reset asserted mid-game: all outputs return to reset values immediately (asynchronous); the FSM resumes in IDLE after release.
- Re-arm from DEFUSED or BOOM: `start` drops for 0 cycles (DEFUSED) or rises after 1 cycle (BOOM). The countdown reload is the countdown block's responsibility.

## Configuration
- `BOMB_STRIKE_LIMIT_EN` defined: `strikes` reaching `MAX_STRIKES` forces BOOM in CHECK.
- Undefined: wrong codes only increment `strikes` (saturating at 3) and clear entry; BOOM only on timer expiry.

## Test plan
- Reset, then arm pulse → `start`=1 one cycle after the pulse; `entry`=0, `digit_cnt`=0.
- Armed, enter 1,2,3,4 → `entry`=16'h1234, `success`=1 two cycles after the 4th pulse, `boom`=0.
- Armed, enter 1,2,3,5 → `strikes`=1, `entry`=0, state ARMED. With macro defined, 3 wrong codes → `boom`=1; without it, `strikes`=3 and `boom`=0.
- Armed, drive {`s2`,`s1`}=8'hFF in the same cycle as the 4th correct enter pulse → `boom`=1, `success`=0.
- Bounce `btn_enter` 0/1 every cycle for 10 cycles, then hold 1 for `DEBOUNCE_CYCLES`+3 cycles → exactly one digit accepted. `sw`=4'hA → `digit_cnt` unchanged.
- Pull `rst` low during CHECK → `start`, `success`, `boom`, `strikes` all 0 immediately; state IDLE after release.
